// File: rtl/pc_hazard_controller.sv
// Pipeline sequencing controller: load-use stall, taken-branch redirect/flush,
// drain-then-halt, plus saturating stall/flush performance counters.
module pc_hazard_controller #(
  parameter int REG_W        = 5,
  parameter int FLUSH_CYCLES = 1,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             IDEX_MemRead,
  input  logic [REG_W-1:0] IDEX_Rt,
  input  logic [REG_W-1:0] IFID_Rs,
  input  logic [REG_W-1:0] IFID_Rt,
  input  logic             IFID_UsesRt,
  input  logic             IFID_Halt,
  input  logic             EXMEM_BrTaken,
  output logic             PCWrite,
  output logic             PCSrc,
  output logic             IFIDWrite,
  output logic             IFIDFlush,
  output logic             IDEXFlush,
  output logic             EXMEMFlush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  localparam int MAXC = (FLUSH_CYCLES > DRAIN_CYCLES) ? FLUSH_CYCLES : DRAIN_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [1:0] {RUN, FLUSH, DRAIN, HALT} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          stall_inc, flush_inc;
  logic          hz;

  // $0 never carries a real dependency, so a load to it cannot cause a stall
  assign hz = IDEX_MemRead && (IDEX_Rt != '0) &&
              ((IDEX_Rt == IFID_Rs) || (IFID_UsesRt && (IDEX_Rt == IFID_Rt)));

  // State, countdown and saturating performance counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      cnt       <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (stall_inc && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (flush_inc && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
    end
  end

  // Next state: branch beats hazard beats halt; a branch during drain cancels the halt
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    case (state)
      RUN: begin
        if (EXMEM_BrTaken) begin
          state_nxt = FLUSH;
          cnt_nxt   = CW'(FLUSH_CYCLES);
          flush_inc = 1'b1;
        end else if (hz) begin
          stall_inc = 1'b1;
        end else if (IFID_Halt) begin
          state_nxt = DRAIN;
          cnt_nxt   = CW'(DRAIN_CYCLES);
        end
      end
      FLUSH: begin
        cnt_nxt = cnt - CW'(1);
        if (cnt <= CW'(1)) state_nxt = RUN;
      end
      DRAIN: begin
        if (EXMEM_BrTaken) begin
          state_nxt = FLUSH;
          cnt_nxt   = CW'(FLUSH_CYCLES);
          flush_inc = 1'b1;
        end else begin
          cnt_nxt = cnt - CW'(1);
          if (cnt <= CW'(1)) state_nxt = HALT;
        end
      end
      default: state_nxt = HALT;
    endcase
  end

  // Pipeline controls, same-cycle from state and inputs; all quiet while in reset
  always_comb begin
    PCWrite    = 1'b0;
    PCSrc      = 1'b0;
    IFIDWrite  = 1'b0;
    IFIDFlush  = 1'b0;
    IDEXFlush  = 1'b0;
    EXMEMFlush = 1'b0;
    halted     = 1'b0;
    if (!rst) begin
      case (state)
        RUN: begin
          if (EXMEM_BrTaken) begin
            PCSrc      = 1'b1;
            IFIDFlush  = 1'b1;
            IDEXFlush  = 1'b1;
            EXMEMFlush = 1'b1;
          end else if (hz) begin
            PCWrite   = 1'b1;
            IFIDWrite = 1'b1;
            IDEXFlush = 1'b1;
          end else if (IFID_Halt) begin
            PCWrite   = 1'b1;
            IFIDWrite = 1'b1;
          end
        end
        FLUSH: IFIDFlush = 1'b1;
        DRAIN: begin
          if (EXMEM_BrTaken) begin
            PCSrc      = 1'b1;
            IFIDFlush  = 1'b1;
            IDEXFlush  = 1'b1;
            EXMEMFlush = 1'b1;
          end else begin
            PCWrite   = 1'b1;
            IFIDWrite = 1'b1;
            IDEXFlush = 1'b1;
          end
        end
        default: begin
          PCWrite   = 1'b1;
          IFIDWrite = 1'b1;
          IDEXFlush = 1'b1;
          halted    = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_hazard_controller.sv
// Directed bench for pc_hazard_controller (CNT_W=4 so saturation is reachable).
module tb_pc_hazard_controller;
  logic       clk = 1'b0;
  logic       rst;
  logic       IDEX_MemRead;
  logic [4:0] IDEX_Rt, IFID_Rs, IFID_Rt;
  logic       IFID_UsesRt, IFID_Halt, EXMEM_BrTaken;
  logic       PCWrite, PCSrc, IFIDWrite, IFIDFlush, IDEXFlush, EXMEMFlush, halted;
  logic [3:0] stall_cnt, flush_cnt;
  logic [6:0] ctl;

  int checks   = 0;
  int failures = 0;

  // {PCWrite,PCSrc,IFIDWrite,IFIDFlush,IDEXFlush,EXMEMFlush,halted}
  localparam logic [6:0] C_NONE  = 7'b0000000;
  localparam logic [6:0] C_STALL = 7'b1010100;
  localparam logic [6:0] C_BR    = 7'b0101110;
  localparam logic [6:0] C_FLUSH = 7'b0001000;
  localparam logic [6:0] C_HREQ  = 7'b1010000;
  localparam logic [6:0] C_DRAIN = 7'b1010100;
  localparam logic [6:0] C_HALT  = 7'b1010101;

  pc_hazard_controller #(.REG_W(5), .FLUSH_CYCLES(1), .DRAIN_CYCLES(3), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .IDEX_MemRead(IDEX_MemRead), .IDEX_Rt(IDEX_Rt),
    .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt), .IFID_UsesRt(IFID_UsesRt),
    .IFID_Halt(IFID_Halt), .EXMEM_BrTaken(EXMEM_BrTaken),
    .PCWrite(PCWrite), .PCSrc(PCSrc), .IFIDWrite(IFIDWrite), .IFIDFlush(IFIDFlush),
    .IDEXFlush(IDEXFlush), .EXMEMFlush(EXMEMFlush), .halted(halted),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  assign ctl = {PCWrite, PCSrc, IFIDWrite, IFIDFlush, IDEXFlush, EXMEMFlush, halted};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change at negedge; combinational outputs are sampled 1ns later
  task automatic drive(input logic r, input logic mr, input logic [4:0] lrt,
                       input logic [4:0] rs, input logic [4:0] rt, input logic ur,
                       input logic h, input logic br);
    @(negedge clk);
    rst = r; IDEX_MemRead = mr; IDEX_Rt = lrt; IFID_Rs = rs; IFID_Rt = rt;
    IFID_UsesRt = ur; IFID_Halt = h; EXMEM_BrTaken = br;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; IDEX_MemRead = 1'b0; IDEX_Rt = '0; IFID_Rs = '0; IFID_Rt = '0;
    IFID_UsesRt = 1'b0; IFID_Halt = 1'b0; EXMEM_BrTaken = 1'b0;

    // Reset held 2 cycles with a hazard and a branch present: controls stay low
    drive(1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b1);
    chk("rst_ctl0", ctl[6:1], 6'd0);
    drive(1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b0);
    chk("rst_ctl1", ctl[6:1], 6'd0);
    chk("rst_stall", stall_cnt, 4'd0);
    chk("rst_flush", flush_cnt, 4'd0);

    // 1: lw $5 / add rs=$5 -> one stall cycle, then the bubble clears it
    drive(1'b0, 1'b1, 5'd5, 5'd5, 5'd9, 1'b0, 1'b0, 1'b0);
    chk("lu_stall", ctl, C_STALL);
    idle();
    chk("lu_release", ctl, C_NONE);
    chk("lu_cnt", stall_cnt, 4'd1);

    // 2: load to $0 never stalls; rt match ignored without UsesRt, honoured with it
    drive(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    chk("r0_nostall", ctl, C_NONE);
    drive(1'b0, 1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0, 1'b0);
    chk("rt_unused", ctl, C_NONE);
    chk("rt_unused_cnt", stall_cnt, 4'd1);
    drive(1'b0, 1'b1, 5'd7, 5'd3, 5'd7, 1'b1, 1'b0, 1'b0);
    chk("rt_used", ctl, C_STALL);
    idle();
    chk("rt_used_cnt", stall_cnt, 4'd2);

    // 3: branch with simultaneous hazard; FLUSH ignores hz, halt and another branch
    drive(1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b1);
    chk("br_ctl", ctl, C_BR);
    drive(1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b1);
    chk("flush_ctl", ctl, C_FLUSH);
    chk("br_flush_cnt", flush_cnt, 4'd1);
    chk("br_stall_cnt", stall_cnt, 4'd2);
    idle();
    chk("flush_done", ctl, C_NONE);
    chk("flush_cnt_hold", flush_cnt, 4'd1);
    chk("stall_cnt_hold", stall_cnt, 4'd2);

    // 4a: halt -> 3 drain cycles -> HALT held for 12 cycles
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    chk("halt_req", ctl, C_HREQ);
    for (int i = 0; i < 3; i++) begin
      idle();
      chk($sformatf("drain%0d", i), ctl, C_DRAIN);
    end
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);
      chk($sformatf("halt%0d", i), ctl, C_HALT);
    end

    // 5a: reset during HALT -> RUN with counters cleared
    drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("halt_rst_ctl", ctl[6:1], 6'd0);
    idle();
    chk("halt_rst_run", ctl, C_NONE);
    chk("halt_rst_stall", stall_cnt, 4'd0);
    chk("halt_rst_flush", flush_cnt, 4'd0);

    // 4b: branch in drain cycle 2 abandons the halt
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    chk("halt2_req", ctl, C_HREQ);
    idle();
    chk("drain2_c1", ctl, C_DRAIN);
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    chk("drain2_br", ctl, C_BR);
    idle();
    chk("drain2_flush", ctl, C_FLUSH);
    chk("drain2_fcnt", flush_cnt, 4'd1);
    idle();
    chk("drain2_run", ctl, C_NONE);
    idle();
    chk("drain2_nohalt", halted, 1'b0);

    // 5b: reset in the middle of FLUSH
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    chk("f_rst_br", ctl, C_BR);
    drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("f_rst_ctl", ctl[6:1], 6'd0);
    chk("f_rst_fcnt_pre", flush_cnt, 4'd2);
    idle();
    chk("f_rst_run", ctl, C_NONE);
    chk("f_rst_fcnt", flush_cnt, 4'd0);
    chk("f_rst_scnt", stall_cnt, 4'd0);

    // 6: 20 back-to-back stalls saturate the 4-bit counter at 15
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b1, 5'd12, 5'd12, 5'd0, 1'b0, 1'b0, 1'b0);
      chk($sformatf("sat_ctl%0d", i), ctl, C_STALL);
      chk($sformatf("sat_cnt%0d", i), stall_cnt, (i > 15) ? 32'd15 : 32'(i));
    end
    idle();
    chk("sat_final", stall_cnt, 4'd15);
    chk("sat_flush", flush_cnt, 4'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
